// File: rtl/bpred_perf_monitor_pkg.sv
// Shared types and constants for the branch-prediction performance monitor.
// Holds the FSM state encoding, the instruction encodings the monitor
// treats specially, the default counter width and the counter-bank indices.
package bpred_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_SAT  = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSN_DEF    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSN_DEF = 32'h0010_0073;
  localparam int unsigned CNT_W_DEF       = 32;

  // Counter bank layout inside the monitor
  localparam int unsigned NUM_CNT   = 4;
  localparam int unsigned IDX_CYC   = 0;
  localparam int unsigned IDX_INSTR = 1;
  localparam int unsigned IDX_BR    = 2;
  localparam int unsigned IDX_MISS  = 3;

endpackage

// File: rtl/bpred_perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (wins over inc_i)
//   inc_i         : count this cycle; ignored once the count is all-ones
//   count_o       : current count
//   at_max_o      : count is all-ones
module sat_counter
  import bpred_perf_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         at_max_o
);

  logic [W-1:0] count_q, count_d;

  assign at_max_o = &count_q;
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !at_max_o) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bpred_perf_monitor.sv
// Branch-prediction performance monitor.
// Counts cycles, retired-looking instructions, resolved branches and
// front-end flushes while running, tracks the worst miss count over full
// windows of WIN_BR branches, and publishes results through a snapshot
// bank with a valid/ready handshake.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   start_i / stop_i     : begin-resume / end counting
//   clear_i              : synchronous clear of everything, back to IDLE
//   snap_req_i           : capture a snapshot while running
//   instr_i              : fetch-stage instruction word
//   br_instr_i, br_miss_i: resolved-branch and flush strobes
//   snap_ready_i         : consumer accepts the snapshot
//   snap_valid_o         : snapshot bank holds unread data
//   overrun_o            : sticky, an unread snapshot was overwritten
//   *_cnt_o, worst_win_miss_o : snapshot contents
//   state_o              : FSM state
//
// state | meaning
// IDLE  | after reset/clear, nothing counted yet
// RUN   | counting events every cycle
// DONE  | stopped by stop_i or a counted EBREAK
// SAT   | a counter reached all-ones; all counters frozen
module bpred_perf_monitor
  import bpred_perf_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WIN_BR      = 64,
  parameter logic [31:0] NOP_INSN    = NOP_INSN_DEF,
  parameter logic [31:0] EBREAK_INSN = EBREAK_INSN_DEF,
  localparam int unsigned WB_W       = $clog2(WIN_BR),
  localparam int unsigned WM_W       = $clog2(WIN_BR) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             snap_req_i,
  input  logic [31:0]      instr_i,
  input  logic             br_instr_i,
  input  logic             br_miss_i,
  input  logic             snap_ready_i,
  output logic             snap_valid_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [WM_W-1:0]  worst_win_miss_o,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] CNT_PRE_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

  state_e state_q, state_d;
  logic   run, ebreak_hit, reach_max, snap_load;

  logic [NUM_CNT-1:0]            inc, at_max;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt, cnt_nxt;

  logic [WB_W-1:0] win_br_q, win_br_d;
  logic [WM_W-1:0] win_miss_q, win_miss_d, win_miss_tot;
  logic [WM_W-1:0] worst_q, worst_d;

  logic [NUM_CNT-1:0][CNT_W-1:0] snap_q, snap_d;
  logic [WM_W-1:0]               snap_worst_q, snap_worst_d;
  logic                          snap_valid_q, snap_valid_d;
  logic                          overrun_q, overrun_d;

  assign run        = (state_q == ST_RUN);
  assign ebreak_hit = run && !br_miss_i && (instr_i == EBREAK_INSN);

  // A flushed fetch slot is a wrong-path instruction, so it never counts.
  always_comb begin
    inc            = '0;
    inc[IDX_CYC]   = run;
    inc[IDX_INSTR] = run && !br_miss_i && (instr_i != '0) && (instr_i != NOP_INSN);
    inc[IDX_BR]    = run && br_instr_i;
    inc[IDX_MISS]  = run && br_miss_i;
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (clear_i),
      .inc_i    (inc[i]),
      .count_o  (cnt[i]),
      .at_max_o (at_max[i])
    );
  end

  // Post-edge counter values, so a snapshot includes this cycle's events.
  // reach_max only fires on the step onto all-ones; an already saturated
  // counter does not push a resumed RUN straight back into SAT.
  always_comb begin
    reach_max = 1'b0;
    cnt_nxt   = cnt;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (inc[i] && !at_max[i]) begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
        if (cnt[i] == CNT_PRE_MAX) reach_max = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (stop_i || ebreak_hit) state_d = ST_DONE;
        else if (reach_max)       state_d = ST_SAT;
      end
      ST_DONE, ST_SAT: if (start_i) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) state_d = ST_IDLE;
  end

  // Window bookkeeping; the closing branch's own miss is part of the window.
  always_comb begin
    win_miss_tot = win_miss_q;
    if (run && br_miss_i && !(&win_miss_q)) win_miss_tot = win_miss_q + WM_W'(1);
    win_br_d   = win_br_q;
    win_miss_d = win_miss_tot;
    worst_d    = worst_q;
    if (run && br_instr_i) begin
      if (win_br_q == WB_W'(WIN_BR - 1)) begin
        if (win_miss_tot > worst_q) worst_d = win_miss_tot;
        win_br_d   = '0;
        win_miss_d = '0;
      end else begin
        win_br_d = win_br_q + WB_W'(1);
      end
    end
    if (clear_i) begin
      win_br_d   = '0;
      win_miss_d = '0;
      worst_d    = '0;
    end
  end

  assign snap_load = run && (snap_req_i || (state_d != ST_RUN));

  always_comb begin
    snap_d       = snap_q;
    snap_worst_d = snap_worst_q;
    snap_valid_d = snap_valid_q;
    overrun_d    = overrun_q;
    if (snap_valid_q && snap_ready_i) snap_valid_d = 1'b0;
    if (snap_load) begin
      snap_d       = cnt_nxt;
      snap_worst_d = worst_d;
      snap_valid_d = 1'b1;
      if (snap_valid_q && !snap_ready_i) overrun_d = 1'b1;
    end
    if (clear_i) begin
      snap_d       = '0;
      snap_worst_d = '0;
      snap_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      win_br_q     <= '0;
      win_miss_q   <= '0;
      worst_q      <= '0;
      snap_q       <= '0;
      snap_worst_q <= '0;
      snap_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_br_q     <= win_br_d;
      win_miss_q   <= win_miss_d;
      worst_q      <= worst_d;
      snap_q       <= snap_d;
      snap_worst_q <= snap_worst_d;
      snap_valid_q <= snap_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign snap_valid_o     = snap_valid_q;
  assign overrun_o        = overrun_q;
  assign cyc_cnt_o        = snap_q[IDX_CYC];
  assign instr_cnt_o      = snap_q[IDX_INSTR];
  assign br_cnt_o         = snap_q[IDX_BR];
  assign miss_cnt_o       = snap_q[IDX_MISS];
  assign worst_win_miss_o = snap_worst_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_bpred_perf_monitor.sv
module tb_bpred_perf_monitor;
  import bpred_perf_pkg::*;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] BEQ    = 32'h0000_0063;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] ins;
    logic [31:0] br;
    logic [31:0] miss;
    logic [6:0]  worst;
    logic        ovr;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, clear, snap_req, br, miss, ready;
  logic [31:0] instr;
  logic        snap_valid, overrun;
  logic [31:0] cyc_cnt, instr_cnt, br_cnt, miss_cnt;
  logic [6:0]  worst;
  logic [1:0]  state;

  logic        s_start, s_stop, s_clear, s_snap_req, s_br, s_miss, s_ready;
  logic [31:0] s_instr;
  logic        s_valid, s_overrun;
  logic [3:0]  s_cyc, s_ins, s_brc, s_missc;
  logic [6:0]  s_worst;
  logic [1:0]  s_state;

  snap_t exp_q[$];
  snap_t mon_act, mon_exp;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  bpred_perf_monitor dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .clear_i(clear),
    .snap_req_i(snap_req), .instr_i(instr), .br_instr_i(br), .br_miss_i(miss),
    .snap_ready_i(ready), .snap_valid_o(snap_valid), .overrun_o(overrun),
    .cyc_cnt_o(cyc_cnt), .instr_cnt_o(instr_cnt), .br_cnt_o(br_cnt), .miss_cnt_o(miss_cnt),
    .worst_win_miss_o(worst), .state_o(state)
  );

  bpred_perf_monitor #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .stop_i(s_stop), .clear_i(s_clear),
    .snap_req_i(s_snap_req), .instr_i(s_instr), .br_instr_i(s_br), .br_miss_i(s_miss),
    .snap_ready_i(s_ready), .snap_valid_o(s_valid), .overrun_o(s_overrun),
    .cyc_cnt_o(s_cyc), .instr_cnt_o(s_ins), .br_cnt_o(s_brc), .miss_cnt_o(s_missc),
    .worst_win_miss_o(s_worst), .state_o(s_state)
  );

  // Scoreboard monitor: every accepted snapshot is matched against the queue.
  always @(negedge clk) begin
    if (rst_n && snap_valid && ready) begin
      mon_act = {cyc_cnt, instr_cnt, br_cnt, miss_cnt, worst, overrun};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL snapshot_unexpected: got cyc=%0d instr=%0d br=%0d miss=%0d worst=%0d ovr=%0d, none expected",
                 mon_act.cyc, mon_act.ins, mon_act.br, mon_act.miss, mon_act.worst, mon_act.ovr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL snapshot: got cyc=%0d instr=%0d br=%0d miss=%0d worst=%0d ovr=%0d, expected cyc=%0d instr=%0d br=%0d miss=%0d worst=%0d ovr=%0d",
                   mon_act.cyc, mon_act.ins, mon_act.br, mon_act.miss, mon_act.worst, mon_act.ovr,
                   mon_exp.cyc, mon_exp.ins, mon_exp.br, mon_exp.miss, mon_exp.worst, mon_exp.ovr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"},   32'(state), 32'(ST_IDLE));
    chk({tag, "_valid"},   32'(snap_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_cyc"},     cyc_cnt, 32'd0);
    chk({tag, "_instr"},   instr_cnt, 32'd0);
    chk({tag, "_br"},      br_cnt, 32'd0);
    chk({tag, "_miss"},    miss_cnt, 32'd0);
    chk({tag, "_worst"},   32'(worst), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    start = 0; stop = 0; clear = 0; snap_req = 0; br = 0; miss = 0; ready = 1; instr = '0;
    s_start = 0; s_stop = 0; s_clear = 0; s_snap_req = 0; s_br = 0; s_miss = 0; s_ready = 0;
    s_instr = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    chk("reset_s_state", 32'(s_state), 32'(ST_IDLE));
    step();
    step();
    rst_n = 1'b1;
    step();

    // 10 NOP cycles, stop on the last one
    start = 1; step(); start = 0;
    chk("t1_state_run", 32'(state), 32'(ST_RUN));
    instr = NOP;
    for (int i = 1; i <= 10; i++) begin
      stop = (i == 10);
      if (i == 10) exp_q.push_back({32'd10, 32'd0, 32'd0, 32'd0, 7'd0, 1'b0});
      step();
    end
    stop = 0; instr = '0;
    chk("t1_state_done", 32'(state), 32'(ST_DONE));
    chk("t1_valid", 32'(snap_valid), 32'd1);
    step();
    chk("t1_valid_cleared", 32'(snap_valid), 32'd0);

    // Windows: 64 br / 5 miss, 64 br / 12 miss, partial 30 br / 30 miss
    clear = 1; step(); clear = 0;
    chk("t2_clear_state", 32'(state), 32'(ST_IDLE));
    chk("t2_clear_cyc", cyc_cnt, 32'd0);
    start = 1; step(); start = 0;
    for (int i = 0; i < 158; i++) begin
      br = 1; instr = BEQ;
      if (i < 64)       miss = (i < 5);
      else if (i < 128) miss = ((i - 64) < 12);
      else              miss = 1;
      stop = (i == 157);
      if (i == 157) exp_q.push_back({32'd158, 32'd111, 32'd158, 32'd47, 7'd12, 1'b0});
      step();
    end
    br = 0; miss = 0; stop = 0; instr = '0;
    chk("t2_state_done", 32'(state), 32'(ST_DONE));
    chk("t2_worst", 32'(worst), 32'd12);
    step();

    // EBREAK under flush is ignored; clean EBREAK is counted and stops
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    instr = EBRK; miss = 1; step();
    chk("t3_flushed_ebreak_run", 32'(state), 32'(ST_RUN));
    miss = 0; instr = ADDI; step();
    instr = EBRK;
    exp_q.push_back({32'd3, 32'd2, 32'd0, 32'd1, 7'd0, 1'b0});
    step();
    instr = '0;
    chk("t3_ebreak_done", 32'(state), 32'(ST_DONE));
    step();

    // Two snapshots without a reader: second overwrites and flags overrun
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    ready = 0; instr = ADDI; snap_req = 1; step();
    chk("t4_valid_first", 32'(snap_valid), 32'd1);
    chk("t4_overrun_first", 32'(overrun), 32'd0);
    step();
    snap_req = 0; instr = '0;
    chk("t4_overrun_set", 32'(overrun), 32'd1);
    chk("t4_second_cyc", cyc_cnt, 32'd2);
    chk("t4_second_instr", instr_cnt, 32'd2);
    step();
    chk("t4_stable_cyc", cyc_cnt, 32'd2);
    exp_q.push_back({32'd2, 32'd2, 32'd0, 32'd0, 7'd0, 1'b1});
    ready = 1; step();
    chk("t4_valid_after_accept", 32'(snap_valid), 32'd0);
    stop = 1;
    exp_q.push_back({32'd5, 32'd2, 32'd0, 32'd0, 7'd0, 1'b1});
    step(); stop = 0;
    chk("t4_state_done", 32'(state), 32'(ST_DONE));
    step();

    // clear together with start mid-run: clear wins, everything zero
    start = 1; step(); start = 0;
    instr = ADDI; br = 1; step(3);
    clear = 1; start = 1; step(); clear = 0; start = 0; br = 0; instr = '0;
    chk_all_zero("t5_clear");
    step(2);
    chk("t5_still_idle", 32'(state), 32'(ST_IDLE));

    // Asynchronous reset mid-run with pending snapshot and overrun
    start = 1; step(); start = 0;
    ready = 0; snap_req = 1; step(2); snap_req = 0;
    chk("t6_pre_overrun", 32'(overrun), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    step();
    rst_n = 1'b1; ready = 1;
    step();
    chk("t6_no_snapshot", 32'(snap_valid), 32'd0);

    // 4-bit counters: saturation then resume with frozen cycle count
    s_start = 1; step(); s_start = 0;
    s_instr = NOP;
    step(14);
    chk("t7_run_at_14", 32'(s_state), 32'(ST_RUN));
    step();
    chk("t7_state_sat", 32'(s_state), 32'(ST_SAT));
    chk("t7_valid", 32'(s_valid), 32'd1);
    chk("t7_cyc", 32'(s_cyc), 32'd15);
    chk("t7_instr", 32'(s_ins), 32'd0);
    step(2);
    chk("t7_sat_holds", 32'(s_state), 32'(ST_SAT));
    s_start = 1; step(); s_start = 0;
    chk("t7_resume_run", 32'(s_state), 32'(ST_RUN));
    step(2);
    chk("t7_still_run", 32'(s_state), 32'(ST_RUN));
    s_snap_req = 1; step(); s_snap_req = 0;
    chk("t7_frozen_cyc", 32'(s_cyc), 32'd15);
    chk("t7_overrun", 32'(s_overrun), 32'd1);

    step(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpred_perf_monitor.md
# bpred_perf_monitor

Branch-prediction performance monitor that sits directly downstream of the pipelined core in the benchmark harness. It consumes the core's fetch-stage instruction, resolved-branch strobe and front-end flush (misprediction) strobe. It accumulates cycle, instruction, branch and misprediction counts, plus the worst per-window miss count. Results are published through a snapshot register bank with a valid/ready handshake, so the same monitor compares every predictor variant.

## Interface
- CNT_W, 32, width of every event counter
- WIN_BR, 64, branches per measurement window (power of two, ≥ 2)
- NOP_INSN, 32'h0000_0013, encoding excluded from instruction count
- EBREAK_INSN, 32'h0010_0073, end-of-program marker

- clk_i  in  1  single clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  begin/resume counting
- stop_i  in  1  end counting
- clear_i  in  1  synchronous clear of all counters and state
- snap_req_i  in  1  capture snapshot while running
- instr_i  in  32  fetch-stage instruction
- br_instr_i  in  1  branch/jump resolved in EX/MEM this cycle
- br_miss_i  in  1  front-end flush (misprediction) this cycle
- snap_ready_i  in  1  consumer accepts snapshot
- snap_valid_o  out  1  snapshot registers hold unread data
- overrun_o  out  1  sticky: snapshot overwritten while unread
- cyc_cnt_o, instr_cnt_o, br_cnt_o, miss_cnt_o  out  CNT_W  snapshot counters
- worst_win_miss_o  out  $clog2(WIN_BR)+1  worst window miss count (snapshot)
- state_o  out  2  FSM state (IDLE=0, RUN=1, DONE=2, SAT=3)

## Operation
- FSM: IDLE -start_i-> RUN; RUN -stop_i or counted EBREAK-> DONE; RUN -any live counter reaching all-ones-> SAT; DONE/SAT -start_i-> RUN (counters resume, not cleared). In RUN, stop_i beats start_i; stop_i ignored outside RUN.
- clear_i highest priority: live and snapshot counters, window state, snap_valid_o, overrun_o to 0; state IDLE.
- Per RUN cycle: cyc +1; br +1 if br_instr_i; miss +1 if br_miss_i (independent of br_instr_i; JALR flushes count); instr +1 if !br_miss_i and instr_i ∉ {0, NOP_INSN}.
- EBREAK: instr_i == EBREAK_INSN and !br_miss_i in RUN → counted, then DONE.
- Counters saturate at 2^CNT_W−1; the SAT transition freezes all counters.
- Window: win_br counts branches, win_miss counts misses. On a branch with win_br == WIN_BR−1, the window closes: worst = max(worst, win_miss + this-cycle miss); both window counters reset. A partial window is never compared.
- Snapshot load: on snap_req_i in RUN, or on RUN→DONE/RUN→SAT. Loads the live next-state values (same-cycle events included).
- Handshake: snap_valid_o rises the cycle after a load; holds until snap_valid_o & snap_ready_i, then clears. A load in the same cycle as acceptance keeps valid high with new data. A load while valid & !snap_ready_i overwrites and sets overrun_o.

## Timing
- All outputs 0 in reset; state_o = IDLE.
- Event at cycle t → live counter at edge t+1; snapshot visible, snap_valid_o=1 at t+1 when loaded at t.
- start_i at t → first counted cycle t+1.
- Reset mid-run: immediate asynchronous return to all-zero; no snapshot emitted.
- Snapshot outputs change only on a load; stable while snap_valid_o is high and no load occurs.

## Structure
- Package bpred_perf_pkg: state enum, NOP/EBREAK constants, default CNT_W.
- Sub-module sat_counter (parameter W; inc, clr; outputs count and at_max), instantiated four times. Window and worst logic stays inline.

## Test plan
- Reset, start, 10 cycles of NOP with no branches, stop → cyc=10, instr=0, br=0, miss=0, snap_valid_o=1, state DONE.
- 64 branches with 5 misses, then 64 with 12, then 30 with 30 → worst_win_miss_o=12 (partial window ignored), br=158, miss=47.
- EBREAK fetched with br_miss_i=0 → counted; state DONE next cycle. Same word with br_miss_i=1 → ignored, still RUN.
- CNT_W=4, 15 cycles → cyc=15, state SAT, snap_valid_o=1; start_i → RUN, counters still frozen at 15.
- snap_req_i twice with snap_ready_i=0 → overrun_o=1, second values shown; snap_ready_i=1 → snap_valid_o=0 next cycle.
- clear_i asserted with start_i mid-run → all outputs 0, state IDLE.
